iter_shifter: RTL

Multi-cycle, bit-serial shift/rotate unit that shares the operation encoding of the single-cycle barrel shifter. It adds the rotate-right path as a first-class operation and trades latency for area: one bit position per clock. It sits beside the ALU as a start/done co-processor for the execute stage. The stage stalls while `busy` is high.

---
 rtl/iter_shifter.sv | 116 +++++++++++
 1 files changed

// File: rtl/iter_shifter.sv
// Bit-serial shift/rotate co-processor: one bit position per clock, start/done handshake.
// Oper encoding shared with the barrel shifter: Oper[1]=right, Oper[0]=shift (vs rotate).
`timescale 1ns/1ps
module iter_shifter #(
  parameter int OPERAND_WIDTH = 16,
  parameter int SHAMT_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [OPERAND_WIDTH-1:0] In,
  input  logic [SHAMT_WIDTH-1:0]   ShAmt,
  input  logic [1:0]               Oper,
  output logic                     busy,
  output logic                     done,
  output logic [OPERAND_WIDTH-1:0] Out
);

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [OPERAND_WIDTH-1:0] data;
  logic [OPERAND_WIDTH-1:0] data_step;
  logic [OPERAND_WIDTH-1:0] data_nxt;
  logic [SHAMT_WIDTH-1:0]   cnt;
  logic [SHAMT_WIDTH-1:0]   cnt_nxt;
  logic [1:0]               op;
  logic                     accepting;
  logic                     accept;
  logic                     last_step;

  // DONE accepts a new start so back-to-back ops have no idle bubble.
  assign accepting = (state == IDLE) || (state == DONE);
  assign accept    = accepting && start;
  assign last_step = (state == SHIFT) && (cnt == SHAMT_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = (ShAmt == '0) ? DONE : SHIFT;
        else        state_nxt = IDLE;
      end
      SHIFT:   state_nxt = last_step ? DONE : SHIFT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    data_step = data;
    case (op)
      OP_ROL:  data_step = {data[OPERAND_WIDTH-2:0], data[OPERAND_WIDTH-1]};
      OP_SLL:  data_step = {data[OPERAND_WIDTH-2:0], 1'b0};
      OP_ROR:  data_step = {data[0], data[OPERAND_WIDTH-1:1]};
      OP_SRL:  data_step = {1'b0, data[OPERAND_WIDTH-1:1]};
      default: data_step = data;
    endcase
  end

  always_comb begin
    data_nxt = data;
    cnt_nxt  = cnt;
    if (accept) begin
      data_nxt = In;
      cnt_nxt  = ShAmt;
    end else if (state == SHIFT) begin
      data_nxt = data_step;
      cnt_nxt  = cnt - SHAMT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      cnt  <= '0;
      op   <= OP_ROL;
    end else begin
      data <= data_nxt;
      cnt  <= cnt_nxt;
      if (accept) op <= Oper;
    end
  end

  // Out only moves on the edge entering DONE; data_nxt is the final value there
  // (shifted result, or In itself for a zero shift).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    Out <= '0;
    else if (state_nxt == DONE) Out <= data_nxt;
  end

endmodule
